sisc_core_p: RTL and testbench

Parametrised multicycle successor to the fixed 32-bit SISC datapath/controller pair. Uses the same 32-bit instruction encoding, register file, ALU, status register and PC/branch logic, with configurable data width, register count and reset vector. Instruction and data memories are external and use req/ack handshakes, so they may have any latency. Sits as the processor tile between the testbench or system bus and the memories.

---
 rtl/sisc_core_p.sv | 216 +++++++++++++++++++++
 tb/tb_sisc_core_p.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_core_p.sv
// sisc_core_p: parametrised multicycle SISC processor tile.
//
// Executes the 32-bit SISC encoding (op/mm/rd/rs/rt/imm16) one instruction at
// a time through FETCH -> DECODE -> EXECUTE -> {MEM ->} WRITEBACK. Both memory
// ports use a req/ack handshake, so instruction and data memories may take any
// number of cycles to respond.
//
// Ports:
//   clk, rst_f                 clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata    instruction fetch port (addr = PC)
//   dmem_req/we/addr/wdata     data access request (we=1 store, 0 load)
//   dmem_ack/rdata             data access completion / load data
//   stat_out                   status flags {C,V,N,Z}
//   pc_out                     current PC
//   halted                     core stopped by HLT (until reset)
module sisc_core_p #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int NREG   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [3:0]        stat_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam int MSB = DATA_W - 1;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg;
    logic [31:0]         ir_reg;
    logic [3:0]          stat_reg;
    logic [DATA_W-1:0]   a_reg, b_reg, d_reg, res_reg;
    logic [ADDR_W-1:0]   addr_reg;

    logic [3:0]          op, mm, rd, rs, rt;
    logic [DATA_W-1:0]   imm_ext;
    logic [ADDR_W-1:0]   imm_a;
    logic [DATA_W-1:0]   rf_view [16];

    assign op      = ir_reg[31:28];
    assign mm      = ir_reg[27:24];
    assign rd      = ir_reg[23:20];
    assign rs      = ir_reg[19:16];
    assign rt      = ir_reg[15:12];
    assign imm_ext = DATA_W'($signed(ir_reg[15:0]));
    assign imm_a   = ir_reg[ADDR_W-1:0];

    // Register file: R0 and indices beyond NREG are hard zero with no storage.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rf
            if (gi != 0 && gi < NREG) begin : g_impl
                logic [DATA_W-1:0] r_reg;
                always_ff @(posedge clk or negedge rst_f) begin
                    if (!rst_f)
                        r_reg <= '0;
                    else if (state_reg == S_WB && rd == 4'(gi))
                        r_reg <= res_reg;
                end
                assign rf_view[gi] = r_reg;
            end else begin : g_zero
                assign rf_view[gi] = '0;
            end
        end
    endgenerate

    // ALU: carry/overflow derived from a one-bit-wider add and subtract.
    logic [DATA_W:0]   sum_ext, diff_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v, alu_valid;

    assign sum_ext   = {1'b0, a_reg} + {1'b0, b_reg};
    assign diff_ext  = {1'b0, a_reg} - {1'b0, b_reg};
    assign alu_valid = ~mm[3];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (mm[2:0])
            3'd0: begin
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (a_reg[MSB] == b_reg[MSB]) && (alu_res[MSB] != a_reg[MSB]);
            end
            3'd1: begin
                alu_res = diff_ext[MSB:0];
                alu_c   = ~diff_ext[DATA_W];
                alu_v   = (a_reg[MSB] != b_reg[MSB]) && (alu_res[MSB] != a_reg[MSB]);
            end
            3'd2: alu_res = a_reg & b_reg;
            3'd3: alu_res = a_reg | b_reg;
            3'd4: alu_res = a_reg ^ b_reg;
            3'd5: alu_res = ~a_reg;
            3'd6: begin
                alu_res = {a_reg[MSB-1:0], 1'b0};
                alu_c   = a_reg[MSB];
            end
            default: begin
                alu_res = {1'b0, a_reg[MSB:1]};
                alu_c   = a_reg[0];
            end
        endcase
    end

    // BRA/BRR: taken when unconditional (mm=0) or any selected flag set.
    // BNE/BNR: taken when none of the selected flags is set.
    logic take_pos, take_neg;
    assign take_pos = (mm == 4'h0) || ((stat_reg & mm) != 4'h0);
    assign take_neg = ((stat_reg & mm) == 4'h0);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (imem_ack) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (op)
                    4'h1, 4'h2: state_next = alu_valid ? S_WB : S_FETCH;
                    4'h8, 4'hC: state_next = S_MEM;
                    4'hF:       state_next = S_HALT;
                    default:    state_next = S_FETCH;
                endcase
            end
            S_MEM:    if (dmem_ack) state_next = (op == 4'h8) ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_reg   <= RESET_PC;
            ir_reg   <= '0;
            stat_reg <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            d_reg    <= '0;
            res_reg  <= '0;
            addr_reg <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_reg <= imem_rdata;
                        pc_reg <= pc_reg + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    a_reg <= rf_view[rs];
                    b_reg <= (op == 4'h2) ? imm_ext : rf_view[rt];
                    d_reg <= rf_view[rd];
                end
                S_EXEC: begin
                    case (op)
                        4'h1, 4'h2: begin
                            if (alu_valid) begin
                                res_reg  <= alu_res;
                                stat_reg <= {alu_c, alu_v, alu_res[MSB], alu_res == '0};
                            end
                        end
                        4'h4: if (take_pos) pc_reg <= imm_a;
                        4'h5: if (take_pos) pc_reg <= pc_reg + imm_a;
                        4'h6: if (take_neg) pc_reg <= imm_a;
                        4'h7: if (take_neg) pc_reg <= pc_reg + imm_a;
                        4'h8, 4'hC: addr_reg <= a_reg[ADDR_W-1:0] + imm_a;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack && op == 4'h8)
                        res_reg <= dmem_rdata;
                end
                default: ;
            endcase
        end
    end

    // imem_req is gated by rst_f so a pending fetch drops the moment reset
    // asserts; the data port drops with the asynchronous state reset.
    assign imem_req   = rst_f && (state_reg == S_FETCH);
    assign imem_addr  = pc_reg;
    assign dmem_req   = (state_reg == S_MEM);
    assign dmem_we    = dmem_req && (op == 4'hC);
    assign dmem_addr  = addr_reg;
    assign dmem_wdata = d_reg;
    assign stat_out   = stat_reg;
    assign pc_out     = pc_reg;
    assign halted     = (state_reg == S_HALT);

endmodule

// File: tb/tb_sisc_core_p.sv
// Self-checking bench for sisc_core_p: a 16-bit instance with a wait-state
// data memory, and a 64-bit / 4-register instance with a nonzero reset vector.
module tb_sisc_core_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end else begin
            $display("ok   %s value=%h", nm, act);
        end
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] mm,
                                        input logic [3:0] rd, input logic [3:0] rs,
                                        input logic [15:0] imm);
        return {op, mm, rd, rs, imm};
    endfunction

    function automatic logic [15:0] rt(input logic [3:0] r);
        return {r, 12'h000};
    endfunction

    // ---------------- DUT0: DATA_W=16 ----------------
    logic        rst0 = 1'b0;
    logic        imem_req0, imem_ack0, dmem_req0, dmem_we0, dmem_ack0, halted0;
    logic [15:0] imem_addr0, dmem_addr0, pc_out0;
    logic [31:0] imem_rdata0;
    logic [15:0] dmem_wdata0, dmem_rdata0;
    logic [3:0]  stat_out0;
    logic [31:0] imem0 [65536];
    logic [15:0] dmem0 [65536];
    int          dwait = 0;
    int          dcnt = 0;
    logic        force_ack0 = 1'b0;

    sisc_core_p #(.DATA_W(16), .ADDR_W(16), .NREG(16), .RESET_PC(16'h0000)) dut0 (
        .clk(clk), .rst_f(rst0),
        .imem_req(imem_req0), .imem_addr(imem_addr0), .imem_ack(imem_ack0), .imem_rdata(imem_rdata0),
        .dmem_req(dmem_req0), .dmem_we(dmem_we0), .dmem_addr(dmem_addr0), .dmem_wdata(dmem_wdata0),
        .dmem_ack(dmem_ack0), .dmem_rdata(dmem_rdata0),
        .stat_out(stat_out0), .pc_out(pc_out0), .halted(halted0)
    );

    assign imem_ack0   = imem_req0;
    assign imem_rdata0 = imem0[imem_addr0];
    assign dmem_ack0   = (dmem_req0 && dcnt == dwait) || force_ack0;
    assign dmem_rdata0 = dmem0[dmem_addr0];

    always @(posedge clk) begin
        if (dmem_req0 && !dmem_ack0) dcnt <= dcnt + 1;
        else                         dcnt <= 0;
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [63:0] data;
        int          rc;
    } acc_t;

    acc_t        acc0 [$];
    acc_t        acc1 [$];
    logic [15:0] f_addr [$];
    int          f_cyc [$];
    int          stab_err = 0;
    logic        in_req = 1'b0;
    int          rc = 0;
    logic [15:0] l_addr, l_wdata;
    logic        l_we;

    // Negedge monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (imem_req0 && imem_ack0) begin
            f_addr.push_back(imem_addr0);
            f_cyc.push_back(cyc);
        end
        if (dmem_req0) begin
            if (!in_req) begin
                in_req  = 1'b1;
                rc      = 1;
                l_addr  = dmem_addr0;
                l_wdata = dmem_wdata0;
                l_we    = dmem_we0;
            end else begin
                rc++;
                if (dmem_addr0 !== l_addr || dmem_wdata0 !== l_wdata || dmem_we0 !== l_we)
                    stab_err++;
            end
            if (dmem_ack0) begin
                acc0.push_back('{dmem_we0, dmem_addr0, {48'h0, dmem_wdata0}, rc});
                if (dmem_we0) dmem0[dmem_addr0] = dmem_wdata0;
                in_req = 1'b0;
            end
        end else begin
            in_req = 1'b0;
        end
    end

    // ---------------- DUT1: DATA_W=64, NREG=4, RESET_PC=0x100 ----------------
    logic        rst1 = 1'b0;
    logic        imem_req1, dmem_req1, dmem_we1, halted1;
    logic [15:0] imem_addr1, dmem_addr1, pc_out1;
    logic [31:0] imem1 [65536];
    logic [63:0] dmem_wdata1;
    logic [3:0]  stat_out1;

    sisc_core_p #(.DATA_W(64), .ADDR_W(16), .NREG(4), .RESET_PC(16'h0100)) dut1 (
        .clk(clk), .rst_f(rst1),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(imem_req1), .imem_rdata(imem1[imem_addr1]),
        .dmem_req(dmem_req1), .dmem_we(dmem_we1), .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
        .dmem_ack(dmem_req1), .dmem_rdata(64'h0),
        .stat_out(stat_out1), .pc_out(pc_out1), .halted(halted1)
    );

    always @(negedge clk) begin
        if (dmem_req1 && dmem_we1)
            acc1.push_back('{1'b1, dmem_addr1, dmem_wdata1, 1});
    end

    // ---------------- helpers ----------------
    task automatic clear_imem0();
        for (int i = 0; i < 65536; i++) imem0[i] = 32'h0;
    endtask

    task automatic clear_logs();
        acc0.delete();
        f_addr.delete();
        f_cyc.delete();
        stab_err = 0;
    endtask

    task automatic start0();
        rst0 = 1'b0;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear_logs();
        rst0 = 1'b1;
    endtask

    task automatic run0(input string nm);
        int n = 0;
        while (!halted0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_halt"}, 64'(halted0), 64'h1);
    endtask

    function automatic int lat(input int k);
        if (f_cyc.size() > k + 1) return f_cyc[k+1] - f_cyc[k];
        return -1;
    endfunction

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  stat;
        int          lat;
    } alu_vec_t;

    alu_vec_t vt [14];

    initial begin
        vt[0]  = '{"add_ovf",  4'h1, 4'h0, 16'h7FFF, 16'h7FFF, 16'hFFFE, 4'b0110, 4};
        vt[1]  = '{"sub_zero", 4'h1, 4'h1, 16'h7FFF, 16'h7FFF, 16'h0000, 4'b1001, 4};
        vt[2]  = '{"sub_brw",  4'h1, 4'h1, 16'h0001, 16'h0002, 16'hFFFF, 4'b0010, 4};
        vt[3]  = '{"add_cy",   4'h1, 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001, 4};
        vt[4]  = '{"sub_ovf",  4'h1, 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100, 4};
        vt[5]  = '{"and",      4'h1, 4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 4};
        vt[6]  = '{"or",       4'h1, 4'h3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b0010, 4};
        vt[7]  = '{"xor",      4'h1, 4'h4, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001, 4};
        vt[8]  = '{"not",      4'h1, 4'h5, 16'h00FF, 16'h0000, 16'hFF00, 4'b0010, 4};
        vt[9]  = '{"shl",      4'h1, 4'h6, 16'h8001, 16'h0000, 16'h0002, 4'b1000, 4};
        vt[10] = '{"shr",      4'h1, 4'h7, 16'h8001, 16'h0000, 16'h4000, 4'b1000, 4};
        vt[11] = '{"addi_neg", 4'h2, 4'h0, 16'h0005, 16'hFFFF, 16'h0004, 4'b1000, 4};
        vt[12] = '{"alu_nop",  4'h1, 4'h9, 16'h0001, 16'h8000, 16'h0000, 4'b0010, 3};
        vt[13] = '{"subi_z",   4'h2, 4'h1, 16'h0003, 16'h0003, 16'h0000, 4'b1001, 4};

        for (int i = 0; i < 65536; i++) begin
            imem0[i] = 32'h0;
            dmem0[i] = 16'h0;
            imem1[i] = 32'h0;
        end

        // ---- reset / first fetch ----
        imem0[0] = ins(4'hF, 0, 0, 0, 16'h0);
        rst0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", 64'(pc_out0), 64'h0);
        chk("rst_stat", 64'(stat_out0), 64'h0);
        chk("rst_dmem_req", 64'(dmem_req0), 64'h0);
        rst0 = 1'b1;
        #1;
        chk("fetch_req", 64'(imem_req0), 64'h1);
        chk("fetch_addr", 64'(imem_addr0), 64'h0);
        @(posedge clk);
        #1;
        chk("fetch_pc_inc", 64'(pc_out0), 64'h1);

        // ---- ALU table ----
        dwait = 0;
        foreach (vt[k]) begin
            clear_imem0();
            imem0[0] = ins(4'h2, 4'h0, 4'd1, 4'd0, vt[k].a);
            imem0[1] = ins(4'h2, 4'h0, 4'd2, 4'd0, vt[k].b);
            imem0[2] = (vt[k].op == 4'h2) ? ins(4'h2, vt[k].mm, 4'd3, 4'd1, vt[k].b)
                                          : ins(4'h1, vt[k].mm, 4'd3, 4'd1, rt(4'd2));
            imem0[3] = ins(4'hC, 4'h0, 4'd3, 4'd0, 16'h0040);
            imem0[4] = ins(4'hF, 4'h0, 4'd0, 4'd0, 16'h0);
            start0();
            run0(vt[k].nm);
            chk({vt[k].nm, "_nacc"}, 64'(acc0.size()), 64'h1);
            if (acc0.size() > 0) begin
                chk({vt[k].nm, "_res"}, acc0[0].data, 64'(vt[k].res));
                chk({vt[k].nm, "_addr"}, 64'(acc0[0].addr), 64'h40);
            end
            chk({vt[k].nm, "_stat"}, 64'(stat_out0), 64'(vt[k].stat));
            chk({vt[k].nm, "_lat"}, 64'(lat(2)), 64'(vt[k].lat));
        end

        // ---- branches ----
        begin
            logic [15:0] exp_f [7];
            exp_f = '{16'h0000, 16'h0008, 16'h0009, 16'h0010, 16'h0011, 16'hFFFE, 16'h0001};
            clear_imem0();
            imem0[16'h0000] = ins(4'h4, 4'h0, 0, 0, 16'h0008);
            imem0[16'h0001] = ins(4'hF, 4'h0, 0, 0, 16'h0);
            imem0[16'h0008] = ins(4'h2, 4'h0, 4'd1, 4'd0, 16'h0000);
            imem0[16'h0009] = ins(4'h4, 4'h1, 0, 0, 16'h0010);
            imem0[16'h0010] = ins(4'h7, 4'h1, 0, 0, 16'hFFFD);
            imem0[16'h0011] = ins(4'h4, 4'h0, 0, 0, 16'hFFFE);
            imem0[16'hFFFE] = ins(4'h5, 4'h0, 0, 0, 16'h0002);
            start0();
            run0("branch");
            chk("br_nfetch", 64'(f_addr.size()), 64'd7);
            for (int i = 0; i < 7; i++)
                if (f_addr.size() > i)
                    chk($sformatf("br_fetch%0d", i), 64'(f_addr[i]), 64'(exp_f[i]));
            chk("br_pc_final", 64'(pc_out0), 64'h2);
            chk("br_stat", 64'(stat_out0), 64'h1);
            chk("br_lat", 64'(lat(2)), 64'd3);
        end

        // ---- memory wait states ----
        clear_imem0();
        imem0[0] = ins(4'h2, 4'h0, 4'd1, 4'd0, 16'h7FFF);
        imem0[1] = ins(4'h1, 4'h0, 4'd2, 4'd1, rt(4'd1));
        imem0[2] = ins(4'hC, 4'h0, 4'd2, 4'd0, 16'h0020);
        imem0[3] = ins(4'h8, 4'h0, 4'd4, 4'd0, 16'h0020);
        imem0[4] = ins(4'hC, 4'h0, 4'd4, 4'd0, 16'h0021);
        imem0[5] = ins(4'hF, 4'h0, 4'd0, 4'd0, 16'h0);
        dwait = 3;
        start0();
        run0("mem");
        chk("mem_nacc", 64'(acc0.size()), 64'd3);
        if (acc0.size() == 3) begin
            chk("mem_st_addr", 64'(acc0[0].addr), 64'h20);
            chk("mem_st_data", acc0[0].data, 64'hFFFE);
            chk("mem_st_we", 64'(acc0[0].we), 64'h1);
            chk("mem_st_reqcyc", 64'(acc0[0].rc), 64'd4);
            chk("mem_ld_we", 64'(acc0[1].we), 64'h0);
            chk("mem_ld_reqcyc", 64'(acc0[1].rc), 64'd4);
            chk("mem_r4_addr", 64'(acc0[2].addr), 64'h21);
            chk("mem_r4_data", acc0[2].data, 64'hFFFE);
        end
        chk("mem_stable", 64'(stab_err), 64'h0);
        chk("mem_add_lat", 64'(lat(1)), 64'd4);
        chk("mem_str_lat", 64'(lat(2)), 64'd7);
        chk("mem_lod_lat", 64'(lat(3)), 64'd8);
        chk("mem_stat", 64'(stat_out0), 64'b0110);

        // ---- halt stays quiet ----
        begin
            int nreq = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (imem_req0 || dmem_req0) nreq++;
            end
            chk("halt_no_req", 64'(nreq), 64'h0);
            chk("halt_flag", 64'(halted0), 64'h1);
        end

        // ---- reset during pending load, late ack ignored ----
        begin
            int n = 0;
            clear_imem0();
            dmem0[16'h0020] = 16'h1234;
            imem0[0] = ins(4'h8, 4'h0, 4'd4, 4'd0, 16'h0020);
            imem0[1] = ins(4'hF, 4'h0, 4'd0, 4'd0, 16'h0);
            dwait = 50;
            start0();
            while (!dmem_req0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rm_req_seen", 64'(dmem_req0), 64'h1);
            repeat (2) @(negedge clk);
            rst0 = 1'b0;
            #1;
            chk("rm_dmem_req_drop", 64'(dmem_req0), 64'h0);
            chk("rm_imem_req_drop", 64'(imem_req0), 64'h0);
            chk("rm_pc", 64'(pc_out0), 64'h0);
            force_ack0 = 1'b1;
            imem0[0] = ins(4'hC, 4'h0, 4'd4, 4'd0, 16'h0030);
            imem0[1] = ins(4'hF, 4'h0, 4'd0, 4'd0, 16'h0);
            dwait = 0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            clear_logs();
            rst0 = 1'b1;
            @(negedge clk);
            force_ack0 = 1'b0;
            run0("rm");
            chk("rm_nacc", 64'(acc0.size()), 64'h1);
            if (acc0.size() > 0) begin
                chk("rm_r4_addr", 64'(acc0[0].addr), 64'h30);
                chk("rm_r4_zero", acc0[0].data, 64'h0);
            end
            chk("rm_stat", 64'(stat_out0), 64'h0);
        end

        // ---- 64-bit, 4-register instance ----
        begin
            int n = 0;
            imem1[16'h0100] = ins(4'h2, 4'h0, 4'd5, 4'd0, 16'h0001);
            imem1[16'h0101] = ins(4'h1, 4'h0, 4'd6, 4'd5, rt(4'd5));
            imem1[16'h0102] = ins(4'hC, 4'h0, 4'd5, 4'd0, 16'h0010);
            imem1[16'h0103] = ins(4'hC, 4'h0, 4'd6, 4'd0, 16'h0011);
            imem1[16'h0104] = ins(4'h2, 4'h0, 4'd1, 4'd0, 16'hFFFF);
            imem1[16'h0105] = ins(4'h1, 4'h7, 4'd1, 4'd1, 16'h0);
            imem1[16'h0106] = ins(4'h1, 4'h5, 4'd1, 4'd1, 16'h0);
            imem1[16'h0107] = ins(4'hC, 4'h0, 4'd1, 4'd0, 16'h0012);
            imem1[16'h0108] = ins(4'h1, 4'h6, 4'd2, 4'd1, 16'h0);
            imem1[16'h0109] = ins(4'hC, 4'h0, 4'd2, 4'd0, 16'h0013);
            imem1[16'h010A] = ins(4'hF, 4'h0, 4'd0, 4'd0, 16'h0);
            acc1.delete();
            @(negedge clk);
            rst1 = 1'b1;
            #1;
            chk("p64_reset_vec", 64'(imem_addr1), 64'h0100);
            chk("p64_fetch_req", 64'(imem_req1), 64'h1);
            while (!halted1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("p64_halt", 64'(halted1), 64'h1);
            chk("p64_nacc", 64'(acc1.size()), 64'd4);
            if (acc1.size() == 4) begin
                chk("p64_r5", acc1[0].data, 64'h0);
                chk("p64_r6", acc1[1].data, 64'h0);
                chk("p64_msb", acc1[2].data, 64'h8000_0000_0000_0000);
                chk("p64_shl", acc1[3].data, 64'h0);
                chk("p64_shl_addr", 64'(acc1[3].addr), 64'h13);
            end
            chk("p64_stat", 64'(stat_out1), 64'b1001);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
